ecc_point_unit: RTL

Parametrised, multi-cycle affine point arithmetic unit for short-Weierstrass curves y^2 = x^3 + A*x + B over GF(p). It is the successor to the combinational-inverse point doubler used by the ECC scalar-multiplication path. The unit computes 2P, or P+Q when the add feature is compiled in, using an internal shift-add modular multiplier and a binary modular inverter. It handles the point at infinity and the P = ±Q cases, and uses a start/busy/done handshake.

---
 rtl/ecc_point_unit_if.sv | 33 +++
 rtl/ecc_point_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_point_unit_if.sv
// ecc_point_unit_if: start/busy/done handshake and operand/result bus for
// ecc_point_unit.
//   master: drives start, op, prime, A, B, Px, Py, p_inf, Qx, Qy, q_inf;
//           observes Rx, Ry, r_inf, busy, done
//   slave : the point unit itself
interface ecc_point_unit_if #(parameter int WIDTH = 64);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] prime;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Px;
  logic [WIDTH-1:0] Py;
  logic             p_inf;
  logic [WIDTH-1:0] Qx;
  logic [WIDTH-1:0] Qy;
  logic             q_inf;
  logic [WIDTH-1:0] Rx;
  logic [WIDTH-1:0] Ry;
  logic             r_inf;
  logic             busy;
  logic             done;

  modport master (
    output start, op, prime, A, B, Px, Py, p_inf, Qx, Qy, q_inf,
    input  Rx, Ry, r_inf, busy, done
  );

  modport slave (
    input  start, op, prime, A, B, Px, Py, p_inf, Qx, Qy, q_inf,
    output Rx, Ry, r_inf, busy, done
  );
endinterface

// File: rtl/ecc_point_unit.sv
// ecc_point_unit: multi-cycle affine point doubler / adder for
// y^2 = x^3 + A*x + B over GF(p), with p odd and > 3.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : ecc_point_unit_if.slave (start/op/operands in, R/busy/done out)
// Define ECC_POINT_ADD_EN to compile in P+Q (op=1). Without it the unit
// only doubles and ignores op, Qx, Qy and q_inf.
// B never enters the group law; it is accepted only for interface symmetry.
//
// state | meaning
// IDLE  | waiting for start, operands latched on start
// CHECK | infinity / P=-Q / Py=0 resolution, loads Px*Px for doubling
// NUM   | lambda numerator (3*Px^2+A or Qy-Py)
// DEN   | lambda denominator (2*Py or Qx-Px), seeds the inverter
// INV   | binary extended Euclid, one halving step per cycle
// LAM   | lam = num * den^-1
// X3    | Rx = lam^2 - Px - x2
// Y3    | Ry = lam*(Px - Rx) - Py
// FIN   | publish result, pulse done
module ecc_point_unit #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  ecc_point_unit_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_NUM, S_DEN, S_INV, S_LAM, S_X3, S_Y3, S_FIN
  } state_t;

  function automatic word_t mod_add(input word_t a, input word_t b, input word_t p);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return word_t'(s);
  endfunction

  function automatic word_t mod_sub(input word_t a, input word_t b, input word_t p);
    logic [WIDTH:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + {1'b0, p} - {1'b0, b};
    return word_t'(s);
  endfunction

  // x/2 mod p: odd x is made even by adding the (odd) modulus first.
  function automatic word_t mod_half(input word_t x, input word_t p);
    logic [WIDTH:0] s;
    s = {1'b0, x};
    if (x[0]) s = s + {1'b0, p};
    return word_t'(s >> 1);
  endfunction

  // One MSB-first shift-add step: acc = 2*acc + bit*a, reduced after each term.
  function automatic word_t mul_step(input word_t acc, input word_t a,
                                     input logic bit_b, input word_t p);
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] pp;
    pp = {2'b00, p};
    t  = {1'b0, acc, 1'b0};
    if (t >= pp) t = t - pp;
    if (bit_b) begin
      t = t + {2'b00, a};
      if (t >= pp) t = t - pp;
    end
    return word_t'(t);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  word_t           acc_q, acc_d;
  word_t           ma_q, ma_d;
  word_t           mb_q, mb_d;
  word_t           num_q, num_d;
  word_t           u_q, u_d;
  word_t           v_q, v_d;
  word_t           x1_q, x1_d;
  word_t           x2_q, x2_d;
  word_t           lam_q, lam_d;
  word_t           wx_q, wx_d;
  word_t           wy_q, wy_d;
  logic            winf_q, winf_d;
  word_t           p_q, p_d;
  word_t           a_q, a_d;
  word_t           px_q, px_d;
  word_t           py_q, py_d;
  logic            pinf_q, pinf_d;
  word_t           rx_q, rx_d;
  word_t           ry_q, ry_d;
  logic            rinf_q, rinf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef ECC_POINT_ADD_EN
  word_t           qx_q, qx_d;
  word_t           qy_q, qy_d;
  logic            qinf_q, qinf_d;
  logic            add_q, add_d;
  logic            dbl_q, dbl_d;
`endif

  word_t           x2_sel;
  word_t           inv_res;
  word_t           mul_nxt;
  word_t           rx_new;
  logic            mul_adv;
  logic            unused_inputs;

`ifdef ECC_POINT_ADD_EN
  assign x2_sel        = dbl_q ? px_q : qx_q;
  assign unused_inputs = ^bus.B;
`else
  assign x2_sel        = px_q;
  assign unused_inputs = ^{bus.B, bus.op, bus.Qx, bus.Qy, bus.q_inf};
`endif

  assign inv_res = (u_q == word_t'(1)) ? x1_q : x2_q;
  assign mul_nxt = mul_step(acc_q, ma_q, mb_q[WIDTH-1], p_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    num_d   = num_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    lam_d   = lam_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    winf_d  = winf_q;
    p_d     = p_q;
    a_d     = a_q;
    px_d    = px_q;
    py_d    = py_q;
    pinf_d  = pinf_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rinf_d  = rinf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ECC_POINT_ADD_EN
    qx_d    = qx_q;
    qy_d    = qy_q;
    qinf_d  = qinf_q;
    add_d   = add_q;
    dbl_d   = dbl_q;
`endif
    rx_new  = '0;
    mul_adv = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          p_d     = bus.prime;
          a_d     = bus.A;
          px_d    = bus.Px;
          py_d    = bus.Py;
          pinf_d  = bus.p_inf;
`ifdef ECC_POINT_ADD_EN
          qx_d    = bus.Qx;
          qy_d    = bus.Qy;
          qinf_d  = bus.q_inf;
          add_d   = bus.op;
`endif
          winf_d  = 1'b0;
          wx_d    = '0;
          wy_d    = '0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        state_d = S_NUM;
        // Px^2 is loaded unconditionally; the add path simply never runs it.
        ma_d    = px_q;
        mb_d    = px_q;
        acc_d   = '0;
        cnt_d   = CW'(WIDTH);
`ifdef ECC_POINT_ADD_EN
        dbl_d   = 1'b1;
        if (add_q) begin
          if (pinf_q) begin
            winf_d  = qinf_q;
            wx_d    = qinf_q ? '0 : qx_q;
            wy_d    = qinf_q ? '0 : qy_q;
            state_d = S_FIN;
          end else if (qinf_q) begin
            wx_d    = px_q;
            wy_d    = py_q;
            state_d = S_FIN;
          end else if (px_q == qx_q) begin
            // P = Q falls through to doubling; P = -Q (or 2P with Py=0) is O.
            if (py_q != qy_q || py_q == '0) begin
              winf_d  = 1'b1;
              state_d = S_FIN;
            end
          end else begin
            dbl_d = 1'b0;
          end
        end else
`endif
        if (pinf_q || py_q == '0) begin
          winf_d  = 1'b1;
          state_d = S_FIN;
        end
      end

      S_NUM: begin
`ifdef ECC_POINT_ADD_EN
        if (!dbl_q) begin
          num_d   = mod_sub(qy_q, py_q, p_q);
          state_d = S_DEN;
        end else
`endif
        if (cnt_q != '0) begin
          mul_adv = 1'b1;
        end else begin
          num_d   = mod_add(mod_add(mod_add(acc_q, acc_q, p_q), acc_q, p_q), a_q, p_q);
          state_d = S_DEN;
        end
      end

      S_DEN: begin
`ifdef ECC_POINT_ADD_EN
        u_d = dbl_q ? mod_add(py_q, py_q, p_q) : mod_sub(qx_q, px_q, p_q);
`else
        u_d = mod_add(py_q, py_q, p_q);
`endif
        v_d     = p_q;
        x1_d    = word_t'(1);
        x2_d    = '0;
        state_d = S_INV;
      end

      // Invariants: x1*den = u, x2*den = v (mod p). Odd-odd steps subtract and
      // halve together so every cycle shrinks u*v by at least a factor of 2.
      S_INV: begin
        if (u_q == word_t'(1) || v_q == word_t'(1)) begin
          ma_d    = num_q;
          mb_d    = inv_res;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_LAM;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = mod_half(x1_q, p_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = mod_half(x2_q, p_q);
        end else if (u_q >= v_q) begin
          u_d  = (u_q - v_q) >> 1;
          x1_d = mod_half(mod_sub(x1_q, x2_q, p_q), p_q);
        end else begin
          v_d  = (v_q - u_q) >> 1;
          x2_d = mod_half(mod_sub(x2_q, x1_q, p_q), p_q);
        end
      end

      S_LAM: begin
        if (cnt_q != '0) begin
          mul_adv = 1'b1;
        end else begin
          lam_d   = acc_q;
          ma_d    = acc_q;
          mb_d    = acc_q;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_X3;
        end
      end

      S_X3: begin
        if (cnt_q != '0) begin
          mul_adv = 1'b1;
        end else begin
          rx_new  = mod_sub(mod_sub(acc_q, px_q, p_q), x2_sel, p_q);
          wx_d    = rx_new;
          ma_d    = lam_q;
          mb_d    = mod_sub(px_q, rx_new, p_q);
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_Y3;
        end
      end

      S_Y3: begin
        if (cnt_q != '0) begin
          mul_adv = 1'b1;
        end else begin
          wy_d    = mod_sub(acc_q, py_q, p_q);
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        rx_d    = wx_q;
        ry_d    = wy_q;
        rinf_d  = winf_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (mul_adv) begin
      acc_d = mul_nxt;
      mb_d  = mb_q << 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      num_q   <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      lam_q   <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      winf_q  <= 1'b0;
      p_q     <= '0;
      a_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pinf_q  <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      rinf_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ECC_POINT_ADD_EN
      qx_q    <= '0;
      qy_q    <= '0;
      qinf_q  <= 1'b0;
      add_q   <= 1'b0;
      dbl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      num_q   <= num_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      lam_q   <= lam_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      winf_q  <= winf_d;
      p_q     <= p_d;
      a_q     <= a_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pinf_q  <= pinf_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rinf_q  <= rinf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ECC_POINT_ADD_EN
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      qinf_q  <= qinf_d;
      add_q   <= add_d;
      dbl_q   <= dbl_d;
`endif
    end
  end

  assign bus.Rx    = rx_q;
  assign bus.Ry    = ry_q;
  assign bus.r_inf = rinf_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
